// File: rtl/instruction_fetch_pkg.sv
// -----------------------------------------------------------------------------
// instruction_fetch_pkg
// Shared definitions for the instruction fetch unit:
//   - fetch FSM state encoding (HALT exists only when FETCH_HALT_EN is defined)
//   - default ROM depth / program-counter width
//   - instruction word layout: op [7:6], rx [5:4], ry [3:2], [1:0] unused
//   - default program image used when the top is not given one
// Optional feature macro: FETCH_HALT_EN (adds the HALT state).
// -----------------------------------------------------------------------------
package instruction_fetch_pkg;

   localparam int ROM_DEPTH_DEF = 16;
   localparam int ADDR_W_DEF    = 4;

   typedef enum logic [2:0] {
      IDLE,
      WAIT_STEP,
      READ,
      PRESENT,
      WAIT_DONE,
      ADVANCE
`ifdef FETCH_HALT_EN
      , HALT
`endif
   } fetch_state_e;

   // Instruction word fields, MSB first.
   typedef struct packed {
      logic [1:0] op;
      logic [1:0] rx;
      logic [1:0] ry;
      logic [1:0] rsvd;
   } instr_t;

   // Default program image, word 0 in the least significant byte.
   localparam logic [8*ROM_DEPTH_DEF-1:0] ROM_INIT_DEF = {104'h0, 8'hC4, 8'h46, 8'h05};

endpackage

// File: rtl/instruction_fetch_rom.sv
// -----------------------------------------------------------------------------
// instr_rom
// Synchronous-read instruction ROM, one-cycle read latency. The contents are
// the program image handed down as the INIT parameter (word i in
// INIT[8*i +: 8]).
// Ports:
//   Clock    in   read clock
//   rd_en_i  in   capture the addressed word on this edge
//   addr_i   in   word address
//   data_o   out  registered word, valid the cycle after rd_en_i
// -----------------------------------------------------------------------------
module instr_rom #(
   parameter int                     DEPTH  = 16,
   parameter int                     ADDR_W = 4,
   parameter logic [8*DEPTH-1:0]     INIT   = '0
) (
   input  logic              Clock,
   input  logic              rd_en_i,
   input  logic [ADDR_W-1:0] addr_i,
   output logic [7:0]        data_o
);

   logic [7:0] mem [DEPTH];
   logic [7:0] data_q;

   for (genvar g = 0; g < DEPTH; g++) begin : g_word
      assign mem[g] = INIT[8*g +: 8];
   end

   always_ff @(posedge Clock) begin
      if (rd_en_i) begin
         data_q <= mem[addr_i];
      end
   end

   assign data_o = data_q;

endmodule

// File: rtl/instruction_fetch.sv
// -----------------------------------------------------------------------------
// instruction_fetch
// Fetches 8-bit instruction words from instr_rom and hands them to a
// downstream control circuit, either continuously (Run=1) or one word per
// Step button press (Run=0). A word is presented with isRomDone=0 until the
// consumer pulses Done.
// Ports:
//   Clock      in   single clock, all state on rising edge
//   Reset      in   asynchronous, active-low
//   Run        in   1 = auto-run, 0 = single-step (sampled in IDLE/ADVANCE)
//   Step       in   active-low pushbutton, asynchronous to Clock
//   Done       in   instruction retired (honoured only while presenting)
//   Opcode     out  current instruction word
//   isRomDone  out  active-low: 0 = Opcode valid and stable
//   Pc         out  address of the word on Opcode
//   Halted     out  program end reached (tied 0 unless FETCH_HALT_EN)
// Optional feature macro: FETCH_HALT_EN -- stop in HALT after the last word
// instead of wrapping Pc back to 0.
// -----------------------------------------------------------------------------
module instruction_fetch
   import instruction_fetch_pkg::*;
#(
   parameter int                       ROM_DEPTH = ROM_DEPTH_DEF,
   parameter int                       ADDR_W    = ADDR_W_DEF,
   parameter logic [8*ROM_DEPTH-1:0]   ROM_INIT  = ROM_INIT_DEF
) (
   input  logic              Clock,
   input  logic              Reset,
   input  logic              Run,
   input  logic              Step,
   input  logic              Done,
   output logic [7:0]        Opcode,
   output logic              isRomDone,
   output logic [ADDR_W-1:0] Pc,
   output logic              Halted
);

   localparam logic [ADDR_W-1:0] PC_LAST = ADDR_W'(ROM_DEPTH - 1);

   fetch_state_e      state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [ADDR_W-1:0] pc_inc_d;
   instr_t            opcode_q;
   logic              rom_done_q;
   logic              step_s1_q;
   logic              step_s2_q;
   logic              step_last_q;
   logic              press_d;
   logic              rom_rd_en;
   logic [7:0]        rom_data;
`ifdef FETCH_HALT_EN
   logic              halted_q;
`endif

   // Step synchronizer plus one history flop. Everything idles at 1 (button
   // released) so reset never manufactures a press.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         step_s1_q   <= 1'b1;
         step_s2_q   <= 1'b1;
         step_last_q <= 1'b1;
      end else begin
         step_s1_q   <= Step;
         step_s2_q   <= step_s1_q;
         step_last_q <= step_s2_q;
      end
   end

   // A press is the synchronized falling edge; holding the button is one press.
   assign press_d = step_last_q & ~step_s2_q;

   // Wrap explicitly so non-power-of-two depths still count modulo ROM_DEPTH.
   assign pc_inc_d = (pc_q == PC_LAST) ? '0 : pc_q + 1'b1;

   assign rom_rd_en = (state_q == READ);

   instr_rom #(
      .DEPTH  (ROM_DEPTH),
      .ADDR_W (ADDR_W),
      .INIT   (ROM_INIT)
   ) u_rom (
      .Clock   (Clock),
      .rd_en_i (rom_rd_en),
      .addr_i  (pc_q),
      .data_o  (rom_data)
   );

   // Fetch FSM. isRomDone is registered alongside the state so it is low for
   // exactly the WAIT_DONE cycles. Done and press are only looked at in the
   // states that consume them, which drops a press coinciding with Done.
   always_ff @(posedge Clock or negedge Reset) begin
      if (!Reset) begin
         state_q    <= IDLE;
         pc_q       <= '0;
         opcode_q   <= '0;
         rom_done_q <= 1'b1;
`ifdef FETCH_HALT_EN
         halted_q   <= 1'b0;
`endif
      end else begin
         case (state_q)
            IDLE: begin
               state_q <= Run ? READ : WAIT_STEP;
            end
            WAIT_STEP: begin
               if (press_d) begin
                  state_q <= READ;
               end
            end
            READ: begin
               state_q <= PRESENT;
            end
            PRESENT: begin
               opcode_q   <= instr_t'(rom_data);
               rom_done_q <= 1'b0;
               state_q    <= WAIT_DONE;
            end
            WAIT_DONE: begin
               if (Done) begin
                  rom_done_q <= 1'b1;
                  state_q    <= ADVANCE;
               end
            end
            ADVANCE: begin
`ifdef FETCH_HALT_EN
               if (pc_q == PC_LAST) begin
                  halted_q <= 1'b1;
                  state_q  <= HALT;
               end else
`endif
               begin
                  pc_q    <= pc_inc_d;
                  state_q <= Run ? READ : WAIT_STEP;
               end
            end
`ifdef FETCH_HALT_EN
            HALT: begin
               state_q <= HALT;
            end
`endif
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign Opcode    = opcode_q;
   assign isRomDone = rom_done_q;
   assign Pc        = pc_q;
`ifdef FETCH_HALT_EN
   assign Halted    = halted_q;
`else
   assign Halted    = 1'b0;
`endif

endmodule
